hazard_stall_controller: RTL

HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

---
 rtl/hazard_pkg.sv | 14 +
 rtl/hazard_detector.sv | 47 ++++
 rtl/hazard_stall_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/stall controller: the FSM state
// encoding and the register-number and wait-counter widths.
package hazard_pkg;

  localparam int REG_W  = 4;
  localparam int WAIT_W = 8;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_detector.sv
// Combinational data-hazard detector.
// With forwarding, only a load sitting in EXE can still cause a hazard
// (load-use). Without forwarding, any pending write-back in EXE or MEM
// that a source operand in ID is waiting on is a hazard.
module hazard_detector
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             forward_en,
  output logic             hazard
);

  logic exe_qual;
  logic mem_qual;
  logic exe_match;
  logic mem_match;

  // Qualify each destination, then compare it against the live ID sources
  always_comb begin
    exe_qual  = 1'b0;
    mem_qual  = 1'b0;
    exe_match = 1'b0;
    mem_match = 1'b0;
    hazard    = 1'b0;

    if (forward_en) begin
      exe_qual = exe_wb_en & exe_mem_r_en;
      mem_qual = 1'b0;
    end else begin
      exe_qual = exe_wb_en;
      mem_qual = mem_wb_en;
    end

    exe_match = (id_src1 == exe_dest) || (id_two_src && (id_src2 == exe_dest));
    mem_match = (id_src1 == mem_dest) || (id_two_src && (id_src2 == mem_dest));

    hazard = (exe_qual && exe_match) || (mem_qual && mem_match);
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard and stall controller.
// Combines data hazards, taken branches and SRAM wait states into the
// freeze/bubble/flush controls, watches for a stuck SRAM access (sticky
// timeout) and counts the cycles the PC was held.
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_src1,
  input  logic [REG_W-1:0] ID_src2,
  input  logic             ID_two_src,
  input  logic [REG_W-1:0] EXE_DEST,
  input  logic             EXE_WB_EN,
  input  logic             EXE_MEM_R_EN,
  input  logic [REG_W-1:0] MEM_DEST,
  input  logic             MEM_WB_EN,
  input  logic             forward_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             bubble_id_ex,
  output logic             flush,
  output logic             freeze_pipe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] next_wait_cnt;
  logic              hazard;
  logic              mem_stall;
  logic              count_en;

  hazard_detector u_detector (
    .id_src1      (ID_src1),
    .id_src2      (ID_src2),
    .id_two_src   (ID_two_src),
    .exe_dest     (EXE_DEST),
    .exe_wb_en    (EXE_WB_EN),
    .exe_mem_r_en (EXE_MEM_R_EN),
    .mem_dest     (MEM_DEST),
    .mem_wb_en    (MEM_WB_EN),
    .forward_en   (forward_en),
    .hazard       (hazard)
  );

  assign mem_stall = mem_req & ~sram_ready;

  // State and wait-counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_wait_cnt;
    end
  end

  // Next-state logic and priority decode of the pipeline controls
  always_comb begin
    next_state    = state;
    next_wait_cnt = wait_cnt;
    freeze_pc     = 1'b0;
    freeze_if_id  = 1'b0;
    bubble_id_ex  = 1'b0;
    flush         = 1'b0;
    freeze_pipe   = 1'b0;

    case (state)
      RUN: begin
        if (mem_stall) begin
          next_state    = MEM_WAIT;
          next_wait_cnt = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (sram_ready || !mem_req) begin
          next_state    = RUN;
          next_wait_cnt = '0;
        end else if (wait_cnt == WAIT_LIMIT) begin
          next_state = TIMEOUT;
        end else begin
          next_wait_cnt = wait_cnt + WAIT_W'(1);
        end
      end
      TIMEOUT: begin
        next_state = TIMEOUT;
      end
      default: begin
        next_state    = RUN;
        next_wait_cnt = '0;
      end
    endcase

    if (state == TIMEOUT) begin
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      freeze_pipe  = 1'b1;
    end else if (mem_stall) begin
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      freeze_pipe  = 1'b1;
    end else if (branch_taken) begin
      flush        = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (hazard) begin
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      bubble_id_ex = 1'b1;
    end
  end

  assign count_en = freeze_pc && (state != TIMEOUT);

  // Saturating count of cycles the PC was held outside of a timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (count_en && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout <= 1'b0;
    end else if (next_state == TIMEOUT) begin
      mem_timeout <= 1'b1;
    end
  end

endmodule
